// File: rtl/mux_scan_if.sv
// Channel-mux bus: packed channel data and select controls in, selected data and status out.
interface mux_scan_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 1
) ();
    localparam int unsigned SW = $clog2(N);

    logic [N*WIDTH-1:0] d;
    logic [SW-1:0]      sel;
    logic               sel_load;
    logic               mode;
    logic               hold;
    logic [WIDTH-1:0]   z;
    logic               z_valid;
    logic [SW-1:0]      ch;
    logic               wrap;
    logic               sel_err;

    modport master (
        output d, sel, sel_load, mode, hold,
        input  z, z_valid, ch, wrap, sel_err
    );

    modport slave (
        input  d, sel, sel_load, mode, hold,
        output z, z_valid, ch, wrap, sel_err
    );
endinterface

// File: rtl/mux_scan.sv
// Registered N-to-1 channel mux with manual load or timed auto-scan, plus post-switch blanking.
module mux_scan #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DWELL = 12000,
    parameter int unsigned BLANK = 1
) (
    input logic       clk,
    input logic       rst_n,
    mux_scan_if.slave bus
);
    localparam int unsigned SW = $clog2(N);
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
    localparam logic [SW-1:0] ChLast    = SW'(N - 1);
    localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);
    localparam logic [BW-1:0] BlankInit = BW'(BLANK);

    logic [SW-1:0]    ch_q, ch_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             z_valid_q, z_valid_d;
    logic             wrap_q, wrap_d;
    logic             sel_err_q, sel_err_d;
    logic             load_ok;

    assign load_ok = bus.sel_load && (32'(bus.sel) < N);

    always_comb begin
        ch_d      = ch_q;
        dwell_d   = dwell_q;
        wrap_d    = 1'b0;
        sel_err_d = 1'b0;
        if (load_ok) begin
            ch_d    = bus.sel;
            dwell_d = '0;
        end else begin
            sel_err_d = bus.sel_load;
            // Parking the counter at zero in manual mode gives a fresh dwell on entering scan.
            if (!bus.mode) begin
                dwell_d = '0;
            end else if (!bus.hold) begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    ch_d    = (ch_q == ChLast) ? '0 : ch_q + SW'(1);
                    wrap_d  = (ch_q == ChLast);
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
        end
    end

    always_comb begin
        blank_d   = blank_q;
        z_d       = z_q;
        z_valid_d = 1'b0;
        if (ch_d != ch_q) begin
            blank_d = BlankInit;
        end else if (blank_q != '0) begin
            blank_d = blank_q - BW'(1);
        end
        if (blank_q == '0) begin
            z_d       = bus.d[ch_q*WIDTH +: WIDTH];
            z_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q      <= '0;
            dwell_q   <= '0;
            blank_q   <= BlankInit;
            z_q       <= '0;
            z_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            ch_q      <= ch_d;
            dwell_q   <= dwell_d;
            blank_q   <= blank_d;
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
            wrap_q    <= wrap_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.ch      = ch_q;
    assign bus.z       = z_q;
    assign bus.z_valid = z_valid_q;
    assign bus.wrap    = wrap_q;
    assign bus.sel_err = sel_err_q;
endmodule
